// File: rtl/sdr_xfer_sequencer.sv
// -----------------------------------------------------------------------------
// sdr_xfer_sequencer
//
// Steps one SDR private transfer through its frames: address byte, ACK slot,
// then N data bytes with a T-bit after each one. It drives the bit counter's
// enable and direction controls. It consumes the counter's byte-complete pulse
// and the SCL edge strobes. It reports progress, completion and error
// conditions to the controller top FSM.
//
// Ports
//   i_bits_cnt_clk    system clock, shared with the bit counter
//   i_rst_n           asynchronous active-low reset
//   i_seq_start       one-cycle start pulse, honoured only in IDLE
//   i_seq_rnw         1 = read (data bytes RX), 0 = write; latched at start
//   i_seq_len         number of data bytes (0 = address only); latched at start
//   i_seq_abort       synchronous abort, forces DONE from any busy state
//   i_scl_pos_edge    SCL rising-edge strobe
//   i_scl_neg_edge    SCL falling-edge strobe
//   i_cnt_done        bit counter byte-complete pulse
//   i_sda_in          sampled SDA (ACK slot and read T-bit slot)
//   i_data_byte       current TX byte, used to build the write T-bit
//   o_cnt_en          bit counter enable
//   o_ctrl_rx_cnt_en  bit counter RX enable
//   o_regf_rx_tx      bit counter direction, 0 = TX, 1 = RX
//   o_tbit_value      T-bit value to drive in a write T-bit slot
//   o_byte_done       one-cycle pulse per completed data byte
//   o_bytes_xfered    completed data-byte count (saturating)
//   o_seq_busy        high whenever the sequencer is not IDLE
//   o_seq_done        one-cycle completion pulse
//   o_nack_err        sticky: address was NACKed
//   o_tgt_end         sticky: target ended a read early
//   o_state           encoded state for debug
// -----------------------------------------------------------------------------
module sdr_xfer_sequencer #(
    parameter int BYTE_CNT_W = 8
) (
    input  logic                  i_bits_cnt_clk,
    input  logic                  i_rst_n,
    input  logic                  i_seq_start,
    input  logic                  i_seq_rnw,
    input  logic [BYTE_CNT_W-1:0] i_seq_len,
    input  logic                  i_seq_abort,
    input  logic                  i_scl_pos_edge,
    input  logic                  i_scl_neg_edge,
    input  logic                  i_cnt_done,
    input  logic                  i_sda_in,
    input  logic [7:0]            i_data_byte,
    output logic                  o_cnt_en,
    output logic                  o_ctrl_rx_cnt_en,
    output logic                  o_regf_rx_tx,
    output logic                  o_tbit_value,
    output logic                  o_byte_done,
    output logic [BYTE_CNT_W-1:0] o_bytes_xfered,
    output logic                  o_seq_busy,
    output logic                  o_seq_done,
    output logic                  o_nack_err,
    output logic                  o_tgt_end,
    output logic [2:0]            o_state
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ADDR = 3'd1,
        ST_ACK  = 3'd2,
        ST_DATA = 3'd3,
        ST_TBIT = 3'd4,
        ST_DONE = 3'd5
    } state_t;

    state_t state_q, state_d;

    // Transfer parameters captured at start
    logic                  rnw_q;
    logic [BYTE_CNT_W-1:0] len_q;
    logic [BYTE_CNT_W-1:0] count_q;

    // Single-bit slot tracking (ACK and T-bit): a neg edge only closes the
    // slot once a pos edge has been seen inside that same slot.
    logic slot_pos_q;
    logic slot_bit_q;

    logic byte_done_q;
    logic nack_q;
    logic tgt_end_q;
    logic tbit_value_q;

    // Decision signals from the next-state logic
    logic start_accept;
    logic abort_hit;
    logic slot_close;
    logic last_byte;
    logic len_zero;
    logic byte_evt;
    logic nack_set;
    logic tgt_set;
    logic cnt_en_d;
    logic rx_en_d;
    logic rx_tx_d;

    logic [BYTE_CNT_W:0] count_inc;

    assign start_accept = (state_q == ST_IDLE) && i_seq_start;
    // DONE already returns to IDLE next cycle; re-entering it would stretch
    // the completion pulse.
    assign abort_hit    = i_seq_abort && (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign slot_close   = slot_pos_q && i_scl_neg_edge;
    // One bit wider than the counter so count+1 cannot wrap onto len.
    assign count_inc    = {1'b0, count_q} + {{BYTE_CNT_W{1'b0}}, 1'b1};
    assign last_byte    = (count_inc == {1'b0, len_q});
    assign len_zero     = (len_q == '0);

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge i_bits_cnt_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples pre-edge values regardless of block ordering.
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and counter-control decode
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // through the case can leave one unassigned and infer a latch.
        state_d  = state_q;
        cnt_en_d = 1'b0;
        rx_en_d  = 1'b0;
        rx_tx_d  = 1'b0;
        byte_evt = 1'b0;
        nack_set = 1'b0;
        tgt_set  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (i_seq_start) state_d = ST_ADDR;
            end

            ST_ADDR: begin
                cnt_en_d = 1'b1;
                // SCL strobes in this cycle are irrelevant: the slot logic
                // only watches them while in ACK or TBIT.
                if (i_cnt_done) state_d = ST_ACK;
            end

            ST_ACK: begin
                if (slot_close) begin
                    if (slot_bit_q) begin
                        nack_set = 1'b1;
                        state_d  = ST_DONE;
                    end else if (len_zero) begin
                        state_d  = ST_DONE;
                    end else begin
                        state_d  = ST_DATA;
                    end
                end
            end

            ST_DATA: begin
                cnt_en_d = 1'b1;
                rx_en_d  = rnw_q;
                rx_tx_d  = rnw_q;
                if (i_cnt_done) state_d = ST_TBIT;
            end

            ST_TBIT: begin
                if (slot_close) begin
                    byte_evt = 1'b1;
                    if (last_byte) begin
                        state_d = ST_DONE;
                    end else if (rnw_q && !slot_bit_q) begin
                        tgt_set = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort overrides every other transition and kills the counter
        // enable in the same cycle it is seen.
        if (abort_hit) begin
            state_d  = ST_DONE;
            cnt_en_d = 1'b0;
            rx_en_d  = 1'b0;
            byte_evt = 1'b0;
            nack_set = 1'b0;
            tgt_set  = 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // Transfer datapath: latched request, byte count, slot samples, flags
    // -------------------------------------------------------------------------
    always_ff @(posedge i_bits_cnt_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rnw_q        <= 1'b0;
            len_q        <= '0;
            count_q      <= '0;
            slot_pos_q   <= 1'b0;
            slot_bit_q   <= 1'b0;
            byte_done_q  <= 1'b0;
            nack_q       <= 1'b0;
            tgt_end_q    <= 1'b0;
            tbit_value_q <= 1'b0;
        end else begin
            byte_done_q <= byte_evt;

            if (start_accept) begin
                rnw_q     <= i_seq_rnw;
                len_q     <= i_seq_len;
                count_q   <= '0;
                nack_q    <= 1'b0;
                tgt_end_q <= 1'b0;
            end

            if (byte_evt && (count_q != '1)) begin
                count_q <= count_inc[BYTE_CNT_W-1:0];
            end

            if (nack_set) nack_q    <= 1'b1;
            if (tgt_set)  tgt_end_q <= 1'b1;

            // Any state change ends the current slot; otherwise the first
            // pos edge inside ACK/TBIT arms it and captures SDA.
            if (state_d != state_q) begin
                slot_pos_q <= 1'b0;
            end else if (((state_q == ST_ACK) || (state_q == ST_TBIT)) &&
                         i_scl_pos_edge && !slot_pos_q) begin
                slot_pos_q <= 1'b1;
                slot_bit_q <= i_sda_in;
            end

            // Odd parity over the byte just shifted out, held through TBIT.
            if ((state_q == ST_DATA) && i_cnt_done && !rnw_q && !abort_hit) begin
                tbit_value_q <= ~^i_data_byte;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign o_cnt_en         = cnt_en_d;
    assign o_ctrl_rx_cnt_en = rx_en_d;
    assign o_regf_rx_tx     = rx_tx_d;
    assign o_tbit_value     = tbit_value_q;
    assign o_byte_done      = byte_done_q;
    assign o_bytes_xfered   = count_q;
    assign o_seq_busy       = (state_q != ST_IDLE);
    assign o_seq_done       = (state_q == ST_DONE);
    assign o_nack_err       = nack_q;
    assign o_tgt_end        = tgt_end_q;
    assign o_state          = state_q;

endmodule

// File: tb/tb_sdr_xfer_sequencer.sv
// -----------------------------------------------------------------------------
// tb_sdr_xfer_sequencer
//
// Directed bench for sdr_xfer_sequencer. Inputs change 1 ns after the rising
// clock edge; outputs are observed on the falling edge. Each scenario task
// drives its own stimulus and checks its own hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_sdr_xfer_sequencer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start, rnw, abort, pos, neg, cnt_done, sda;
    logic [W-1:0] len;
    logic [7:0]   data;

    logic         o_cnt_en, o_ctrl_rx_cnt_en, o_regf_rx_tx, o_tbit_value;
    logic         o_byte_done, o_seq_busy, o_seq_done, o_nack_err, o_tgt_end;
    logic [W-1:0] o_bytes_xfered;
    logic [2:0]   o_state;

    int total = 0;
    int bad   = 0;

    // Running event counts, sampled on the falling edge
    int mon_bd    = 0;
    int mon_sd    = 0;
    int mon_data  = 0;
    int mon_rxbad = 0;

    always #5 clk = ~clk;

    sdr_xfer_sequencer #(.BYTE_CNT_W(W)) dut (
        .i_bits_cnt_clk   (clk),
        .i_rst_n          (rst_n),
        .i_seq_start      (start),
        .i_seq_rnw        (rnw),
        .i_seq_len        (len),
        .i_seq_abort      (abort),
        .i_scl_pos_edge   (pos),
        .i_scl_neg_edge   (neg),
        .i_cnt_done       (cnt_done),
        .i_sda_in         (sda),
        .i_data_byte      (data),
        .o_cnt_en         (o_cnt_en),
        .o_ctrl_rx_cnt_en (o_ctrl_rx_cnt_en),
        .o_regf_rx_tx     (o_regf_rx_tx),
        .o_tbit_value     (o_tbit_value),
        .o_byte_done      (o_byte_done),
        .o_bytes_xfered   (o_bytes_xfered),
        .o_seq_busy       (o_seq_busy),
        .o_seq_done       (o_seq_done),
        .o_nack_err       (o_nack_err),
        .o_tgt_end        (o_tgt_end),
        .o_state          (o_state)
    );

    always @(negedge clk) begin
        if (o_byte_done) mon_bd++;
        if (o_seq_done)  mon_sd++;
        if (o_state == 3'd3) begin
            mon_data++;
            if (o_regf_rx_tx !== 1'b1 || o_ctrl_rx_cnt_en !== 1'b1) mon_rxbad++;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------------------------------------------------------- helpers
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_xfer(input logic r, input logic [W-1:0] n);
        rnw   = r;
        len   = n;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Two idle bit times, then the counter's byte-complete pulse
    task automatic pulse_cnt_done();
        tick();
        tick();
        cnt_done = 1'b1;
        tick();
        cnt_done = 1'b0;
    endtask

    // One single-bit slot: pos edge carrying s, an idle cycle, then neg edge
    task automatic bit_slot(input logic s);
        sda = s;
        pos = 1'b1;
        tick();
        pos = 1'b0;
        tick();
        neg = 1'b1;
        tick();
        neg = 1'b0;
        sda = 1'b0;
    endtask

    // ---------------------------------------------------------------- tests
    task automatic test_reset();
        #1;
        total++; if (o_state !== 3'd0) begin bad++; $display("FAIL rst_state: got=%0d exp=0", o_state); end
        total++; if ({o_cnt_en, o_ctrl_rx_cnt_en, o_regf_rx_tx, o_tbit_value, o_byte_done,
                      o_seq_busy, o_seq_done, o_nack_err, o_tgt_end} !== 9'b0)
                     begin bad++; $display("FAIL rst_flags: got=%b exp=0", {o_cnt_en, o_ctrl_rx_cnt_en,
                      o_regf_rx_tx, o_tbit_value, o_byte_done, o_seq_busy, o_seq_done, o_nack_err, o_tgt_end}); end
        total++; if (o_bytes_xfered !== 8'd0) begin bad++; $display("FAIL rst_bytes: got=%0d exp=0", o_bytes_xfered); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        // Abort while idle does nothing
        abort = 1'b1;
        tick();
        abort = 1'b0;
        @(negedge clk);
        total++; if (o_state !== 3'd0 || o_seq_done !== 1'b0)
                     begin bad++; $display("FAIL idle_abort: state=%0d done=%b exp state=0 done=0", o_state, o_seq_done); end
    endtask

    task automatic test_write_two();
        int bd0, sd0;
        bd0 = mon_bd;
        sd0 = mon_sd;
        start_xfer(1'b0, 8'd2);
        @(negedge clk);
        total++; if ({o_state, o_cnt_en, o_regf_rx_tx, o_seq_busy} !== {3'd1, 1'b1, 1'b0, 1'b1})
                     begin bad++; $display("FAIL w_addr: st/cnt/rxtx/busy got=%b exp=001101", {o_state, o_cnt_en, o_regf_rx_tx, o_seq_busy}); end
        // Byte-complete together with a pos edge carrying SDA=1: only the
        // byte-complete counts, so no ACK bit is captured here.
        tick();
        cnt_done = 1'b1; pos = 1'b1; sda = 1'b1;
        tick();
        cnt_done = 1'b0; pos = 1'b0; sda = 1'b0;
        @(negedge clk);
        total++; if (o_state !== 3'd2 || o_cnt_en !== 1'b0)
                     begin bad++; $display("FAIL w_ack_enter: state=%0d cnt=%b exp state=2 cnt=0", o_state, o_cnt_en); end
        // Neg edge before any pos edge in the slot is ignored
        neg = 1'b1;
        tick();
        neg = 1'b0;
        @(negedge clk);
        total++; if (o_state !== 3'd2) begin bad++; $display("FAIL w_early_neg: state=%0d exp=2", o_state); end
        bit_slot(1'b0);
        @(negedge clk);
        total++; if ({o_state, o_cnt_en, o_regf_rx_tx, o_ctrl_rx_cnt_en} !== {3'd3, 1'b1, 1'b0, 1'b0})
                     begin bad++; $display("FAIL w_data1: got=%b exp=011100", {o_state, o_cnt_en, o_regf_rx_tx, o_ctrl_rx_cnt_en}); end
        data = 8'hA5;
        pulse_cnt_done();
        @(negedge clk);
        total++; if ({o_state, o_tbit_value, o_cnt_en} !== {3'd4, 1'b1, 1'b0})
                     begin bad++; $display("FAIL w_tbit1: st/tbit/cnt got=%b exp=10010", {o_state, o_tbit_value, o_cnt_en}); end
        bit_slot(1'b1);
        @(negedge clk);
        total++; if ({o_state, o_byte_done} !== {3'd3, 1'b1} || o_bytes_xfered !== 8'd1)
                     begin bad++; $display("FAIL w_byte1: st=%0d bd=%b cnt=%0d exp st=3 bd=1 cnt=1", o_state, o_byte_done, o_bytes_xfered); end
        data = 8'h01;
        pulse_cnt_done();
        @(negedge clk);
        total++; if ({o_state, o_tbit_value} !== {3'd4, 1'b0})
                     begin bad++; $display("FAIL w_tbit2: st/tbit got=%b exp=1000", {o_state, o_tbit_value}); end
        bit_slot(1'b1);
        @(negedge clk);
        total++; if ({o_state, o_seq_done, o_byte_done} !== {3'd5, 1'b1, 1'b1} || o_bytes_xfered !== 8'd2)
                     begin bad++; $display("FAIL w_done: st=%0d sd=%b bd=%b cnt=%0d exp st=5 sd=1 bd=1 cnt=2", o_state, o_seq_done, o_byte_done, o_bytes_xfered); end
        tick();
        @(negedge clk);
        total++; if ({o_state, o_seq_busy, o_seq_done, o_nack_err} !== {3'd0, 3'b000} || o_bytes_xfered !== 8'd2)
                     begin bad++; $display("FAIL w_idle: st=%0d busy=%b sd=%b nack=%b cnt=%0d exp 0/0/0/0/2", o_state, o_seq_busy, o_seq_done, o_nack_err, o_bytes_xfered); end
        tick();
        total++; if (mon_bd - bd0 !== 2 || mon_sd - sd0 !== 1)
                     begin bad++; $display("FAIL w_pulses: byte_done=%0d seq_done=%0d exp 2 and 1", mon_bd - bd0, mon_sd - sd0); end
    endtask

    task automatic test_nack();
        int sd0, dc0;
        sd0 = mon_sd;
        dc0 = mon_data;
        start_xfer(1'b0, 8'd3);
        pulse_cnt_done();
        bit_slot(1'b1);
        @(negedge clk);
        total++; if ({o_state, o_seq_done, o_nack_err} !== {3'd5, 1'b1, 1'b1} || o_bytes_xfered !== 8'd0)
                     begin bad++; $display("FAIL nack_done: st=%0d sd=%b nack=%b cnt=%0d exp 5/1/1/0", o_state, o_seq_done, o_nack_err, o_bytes_xfered); end
        tick();
        @(negedge clk);
        total++; if (o_state !== 3'd0 || o_nack_err !== 1'b1)
                     begin bad++; $display("FAIL nack_sticky: st=%0d nack=%b exp st=0 nack=1", o_state, o_nack_err); end
        tick();
        total++; if (mon_data - dc0 !== 0 || mon_sd - sd0 !== 1)
                     begin bad++; $display("FAIL nack_path: data_cycles=%0d seq_done=%0d exp 0 and 1", mon_data - dc0, mon_sd - sd0); end
    endtask

    task automatic test_read_tgt_end();
        int bd0, rb0, dc0;
        bd0 = mon_bd;
        rb0 = mon_rxbad;
        dc0 = mon_data;
        start_xfer(1'b1, 8'd4);
        @(negedge clk);
        total++; if (o_nack_err !== 1'b0) begin bad++; $display("FAIL r_nack_clear: got=%b exp=0", o_nack_err); end
        pulse_cnt_done();
        bit_slot(1'b0);
        @(negedge clk);
        total++; if ({o_state, o_cnt_en, o_regf_rx_tx, o_ctrl_rx_cnt_en} !== {3'd3, 3'b111})
                     begin bad++; $display("FAIL r_data1: got=%b exp=011111", {o_state, o_cnt_en, o_regf_rx_tx, o_ctrl_rx_cnt_en}); end
        pulse_cnt_done();
        bit_slot(1'b1);
        @(negedge clk);
        total++; if (o_state !== 3'd3 || o_bytes_xfered !== 8'd1 || o_tgt_end !== 1'b0)
                     begin bad++; $display("FAIL r_byte1: st=%0d cnt=%0d tgt=%b exp 3/1/0", o_state, o_bytes_xfered, o_tgt_end); end
        pulse_cnt_done();
        bit_slot(1'b0);
        @(negedge clk);
        total++; if ({o_state, o_seq_done, o_tgt_end} !== {3'd5, 1'b1, 1'b1} || o_bytes_xfered !== 8'd2)
                     begin bad++; $display("FAIL r_tgt_end: st=%0d sd=%b tgt=%b cnt=%0d exp 5/1/1/2", o_state, o_seq_done, o_tgt_end, o_bytes_xfered); end
        tick();
        @(negedge clk);
        total++; if (o_tgt_end !== 1'b1 || o_bytes_xfered !== 8'd2)
                     begin bad++; $display("FAIL r_hold: tgt=%b cnt=%0d exp 1/2", o_tgt_end, o_bytes_xfered); end
        tick();
        total++; if (mon_rxbad - rb0 !== 0 || mon_bd - bd0 !== 2 || mon_data - dc0 == 0)
                     begin bad++; $display("FAIL r_rx_ctrl: rx_bad=%0d byte_done=%0d data_cycles=%0d exp 0/2/nonzero", mon_rxbad - rb0, mon_bd - bd0, mon_data - dc0); end
    endtask

    task automatic test_addr_only();
        int dc0;
        dc0 = mon_data;
        start_xfer(1'b0, 8'd0);
        @(negedge clk);
        total++; if (o_tgt_end !== 1'b0) begin bad++; $display("FAIL a_tgt_clear: got=%b exp=0", o_tgt_end); end
        pulse_cnt_done();
        sda = 1'b0;
        pos = 1'b1;
        tick();
        pos = 1'b0;
        tick();
        neg = 1'b1;
        @(negedge clk);
        total++; if (o_state !== 3'd2 || o_seq_done !== 1'b0)
                     begin bad++; $display("FAIL a_neg_cycle: st=%0d sd=%b exp 2/0", o_state, o_seq_done); end
        tick();
        neg = 1'b0;
        @(negedge clk);
        total++; if (o_state !== 3'd5 || o_seq_done !== 1'b1 || o_nack_err !== 1'b0)
                     begin bad++; $display("FAIL a_done: st=%0d sd=%b nack=%b exp 5/1/0", o_state, o_seq_done, o_nack_err); end
        tick();
        @(negedge clk);
        total++; if (o_state !== 3'd0 || o_seq_done !== 1'b0 || mon_data - dc0 !== 0)
                     begin bad++; $display("FAIL a_idle: st=%0d sd=%b data_cycles=%0d exp 0/0/0", o_state, o_seq_done, mon_data - dc0); end
        tick();
    endtask

    task automatic test_abort();
        int bd0;
        bd0 = mon_bd;
        start_xfer(1'b0, 8'd2);
        pulse_cnt_done();
        bit_slot(1'b0);
        tick();
        // Abort mid-byte; a start pulse in the same window must be ignored
        abort = 1'b1;
        start = 1'b1;
        rnw   = 1'b1;
        len   = 8'd9;
        @(negedge clk);
        total++; if (o_state !== 3'd3 || o_cnt_en !== 1'b0)
                     begin bad++; $display("FAIL ab_cnt_drop: st=%0d cnt=%b exp 3/0", o_state, o_cnt_en); end
        tick();
        abort = 1'b0;
        start = 1'b0;
        @(negedge clk);
        total++; if ({o_state, o_seq_done, o_cnt_en} !== {3'd5, 1'b1, 1'b0} || o_bytes_xfered !== 8'd0)
                     begin bad++; $display("FAIL ab_done: st=%0d sd=%b cnt=%b bytes=%0d exp 5/1/0/0", o_state, o_seq_done, o_cnt_en, o_bytes_xfered); end
        tick();
        tick();
        @(negedge clk);
        total++; if (o_state !== 3'd0 || o_seq_busy !== 1'b0 || mon_bd - bd0 !== 0)
                     begin bad++; $display("FAIL ab_ignored_start: st=%0d busy=%b byte_done=%0d exp 0/0/0", o_state, o_seq_busy, mon_bd - bd0); end
        tick();
    endtask

    task automatic test_reset_mid();
        int sd0;
        sd0 = mon_sd;
        start_xfer(1'b0, 8'd2);
        pulse_cnt_done();
        bit_slot(1'b0);
        data = 8'hA5;
        pulse_cnt_done();
        @(negedge clk);
        total++; if (o_state !== 3'd4 || o_tbit_value !== 1'b1)
                     begin bad++; $display("FAIL rm_pre: st=%0d tbit=%b exp 4/1", o_state, o_tbit_value); end
        #2;
        rst_n = 1'b0;
        #1;
        total++; if ({o_state, o_cnt_en, o_ctrl_rx_cnt_en, o_regf_rx_tx, o_tbit_value, o_byte_done,
                      o_seq_busy, o_seq_done, o_nack_err, o_tgt_end, o_bytes_xfered} !== 20'd0)
                     begin bad++; $display("FAIL rm_async: st=%0d tbit=%b busy=%b bytes=%0d exp all zero", o_state, o_tbit_value, o_seq_busy, o_bytes_xfered); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        start_xfer(1'b0, 8'd1);
        pulse_cnt_done();
        bit_slot(1'b0);
        data = 8'h03;
        pulse_cnt_done();
        @(negedge clk);
        total++; if (o_tbit_value !== 1'b1) begin bad++; $display("FAIL rm_tbit: got=%b exp=1", o_tbit_value); end
        bit_slot(1'b1);
        @(negedge clk);
        total++; if ({o_state, o_seq_done, o_byte_done} !== {3'd5, 1'b1, 1'b1} || o_bytes_xfered !== 8'd1)
                     begin bad++; $display("FAIL rm_rerun: st=%0d sd=%b bd=%b cnt=%0d exp 5/1/1/1", o_state, o_seq_done, o_byte_done, o_bytes_xfered); end
        tick();
        tick();
        total++; if (mon_sd - sd0 !== 1)
                     begin bad++; $display("FAIL rm_no_done: seq_done pulses=%0d exp=1", mon_sd - sd0); end
    endtask

    // ---------------------------------------------------------------- main
    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        rnw      = 1'b0;
        len      = '0;
        abort    = 1'b0;
        pos      = 1'b0;
        neg      = 1'b0;
        cnt_done = 1'b0;
        sda      = 1'b0;
        data     = 8'h00;

        test_reset();
        test_write_two();
        test_nack();
        test_read_tgt_end();
        test_addr_only();
        test_abort();
        test_reset_mid();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sdr_xfer_sequencer.md
Name: sdr_xfer_sequencer

Overview:
- Sequences one SDR private transfer frame-by-frame by driving the bit-counter controls (count enable, RX enable, RX/TX select).
- Frames handled: address byte, ACK slot, N data bytes, each data byte followed by its T-bit.
- Consumes the bit counter's done pulse and SCL edge strobes. Reports progress, completion and errors to the controller top FSM.
- Sits between the controller top FSM and the per-bit counter / serializer.

Parameters:
- BYTE_CNT_W, 8, width of byte-count request and transferred-count output.

Ports:
- i_bits_cnt_clk  in  1  system clock (same clock as the bit counter)
- i_rst_n  in  1  reset
- i_seq_start  in  1  one-cycle start pulse; sampled only in IDLE
- i_seq_rnw  in  1  1 = read (data bytes RX), 0 = write (data bytes TX); latched at start
- i_seq_len  in  BYTE_CNT_W  number of data bytes; latched at start; 0 = address-only
- i_seq_abort  in  1  synchronous abort, any state
- i_scl_pos_edge  in  1  SCL rising-edge strobe, one cycle wide
- i_scl_neg_edge  in  1  SCL falling-edge strobe, one cycle wide
- i_cnt_done  in  1  bit-counter byte-complete pulse
- i_sda_in  in  1  sampled SDA, used in ACK and read T-bit slots
- i_data_byte  in  8  current TX data byte, used for write parity
- o_cnt_en  out  1  bit-counter enable
- o_ctrl_rx_cnt_en  out  1  bit-counter RX enable
- o_regf_rx_tx  out  1  bit-counter direction: 0 = TX, 1 = RX
- o_tbit_value  out  1  T-bit to drive in write TBIT slot
- o_byte_done  out  1  one-cycle pulse per completed data byte, T-bit included
- o_bytes_xfered  out  BYTE_CNT_W  completed data-byte count
- o_seq_busy  out  1  high in any state other than IDLE
- o_seq_done  out  1  one-cycle completion pulse
- o_nack_err  out  1  sticky NACK flag; cleared on the next accepted start
- o_tgt_end  out  1  sticky flag: target ended the read early; cleared on the next accepted start
- o_state  out  3  encoded state, for debug

Behaviour:
- Reset values: all outputs 0, state IDLE, internal length and count registers 0.
- State encoding: IDLE=0, ADDR=1, ACK=2, DATA=3, TBIT=4, DONE=5.
- IDLE:
  - On i_seq_start: latch rnw and len, clear count and sticky flags, go to ADDR on the next cycle.
  - A start outside IDLE is ignored.
- ADDR:
  - o_cnt_en=1, o_regf_rx_tx=0, o_ctrl_rx_cnt_en=0.
  - On i_cnt_done: go to ACK.
- ACK:
  - o_cnt_en=0.
  - On i_scl_pos_edge, sample i_sda_in into an ack register.
  - On the following i_scl_neg_edge:
    - ack=1 (NACK): set o_nack_err, go to DONE.
    - len=0: go to DONE.
    - Otherwise: go to DATA.
- DATA:
  - o_cnt_en=1, o_regf_rx_tx=rnw, o_ctrl_rx_cnt_en=rnw.
  - On i_cnt_done: go to TBIT.
  - For writes, o_tbit_value is registered as ~^i_data_byte (odd parity) when i_cnt_done is seen, and held through TBIT.
- TBIT:
  - o_cnt_en=0.
  - For reads, sample i_sda_in on i_scl_pos_edge.
  - On the following i_scl_neg_edge:
    - Pulse o_byte_done and increment o_bytes_xfered; the count saturates at all-ones.
    - count+1 == len: go to DONE.
    - Read and sampled T-bit = 0: set o_tgt_end, go to DONE.
    - Otherwise: go back to DATA.
- DONE:
  - Pulse o_seq_done for exactly one cycle, return to IDLE.
  - o_bytes_xfered and the sticky flags hold until the next start.
- Abort:
  - i_seq_abort in any non-IDLE state goes to DONE on the next cycle and drops o_cnt_en immediately.
  - Abort in IDLE has no effect.
- Simultaneous events:
  - Abort wins over any other transition.
  - If i_cnt_done and an SCL strobe arrive in the same cycle in ADDR or DATA, only i_cnt_done is acted on.
  - In single-bit slots, an i_scl_neg_edge seen before any i_scl_pos_edge is ignored; the slot waits for the pos edge, then a neg edge.
- Reset mid-transfer: everything returns immediately and asynchronously to the reset values. No o_seq_done is emitted.
- Latency:
  - Start to o_cnt_en high: 1 cycle.
  - Final TBIT neg edge to o_seq_done: 1 cycle (passes through DONE).

Test Plan:
- Write, len=2, data 0xA5 and 0x01, ACK=0 → T-bits 1 and 0; two o_byte_done pulses; o_bytes_xfered=2; single o_seq_done; o_nack_err=0.
- Address phase with i_sda_in=1 in the ACK slot → o_nack_err=1; o_seq_done; o_bytes_xfered=0; no DATA state entered.
- Read, len=4, target T-bit=0 after byte 2 → o_tgt_end=1; o_bytes_xfered=2; o_regf_rx_tx=1 and o_ctrl_rx_cnt_en=1 throughout DATA.
- len=0, ACK=0 → path ADDR→ACK→DONE; o_seq_done one cycle after the ACK neg edge.
- i_seq_abort mid-DATA of byte 1 → o_cnt_en=0 next cycle; o_seq_done one cycle later; o_bytes_xfered=0. A start pulse during busy is ignored.
- i_rst_n asserted in TBIT → all outputs 0 immediately; state IDLE; a new start then runs normally.
